// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh local responder.
// Holds the responder FSM state type, the AXI response and burst encodings,
// the address field positions and small helpers for the response code.
package mesh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  // Address layout: [2:0] byte offset, [5:3] column, [8:6] row, [9+] word index.
  localparam int COL_LSB = 3;
  localparam int ROW_LSB = 6;
  localparam int IDX_LSB = 9;

  // Only 8-byte beats and FIXED/INCR bursts are serviced; anything else is SLVERR.
  function automatic logic [1:0] req_resp(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3 || burst[1]) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // The encodings happen to order by severity (DECERR > SLVERR > OKAY),
  // so the stronger response is simply the numerically larger code.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mesh_resp_mem.sv
// Local storage of the mesh responder: DEPTH words of DATA_W bits.
// Ports:
//   clk, rst_n      clock, asynchronous active-low clear of every word
//   we, waddr       write enable and word index
//   wstrb, wdata    byte enables and write data (one strobe bit per byte)
//   raddr, rdata    combinational read port
module mesh_resp_mem #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 64,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    // NOTE: every combinational output starts from a full default so no path leaves it unassigned (no latch).
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is a flop array, so it can be cleared by reset; a RAM macro could not be.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mesh_local_responder.sv
// Target-side endpoint of the core mesh. Accepts one AXI-style read or write
// burst at a time on the local port and services it from mesh_resp_mem.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   my_x, my_y        this core's column / row
//   s_aw*, s_w*, s_b* write address, data and response channels
//   s_ar*, s_r*       read address and data channels
// Build option: define MESH_RESP_DEST_CHECK_EN to answer requests whose
// row/column bits do not match (my_y, my_x) with DECERR and no storage access.
module mesh_local_responder
  import mesh_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          my_x,
  input  logic [2:0]          my_y,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rlast,
  output logic [1:0]          s_rresp
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic             prio_rd_q, prio_rd_d;   // 1: read wins when both request
  logic [IDX_W-1:0] base_q, base_d;
  logic [7:0]       len_q, len_d;
  logic             fixed_q, fixed_d;
  logic [8:0]       beat_q, beat_d;         // one extra bit to see overrun past 256 beats
  logic [1:0]       resp_q, resp_d;

  logic             grant_r, grant_w;
  logic [1:0]       aw_resp, ar_resp, w_resp;
  logic [IDX_W-1:0] step, idx;
  logic             last_beat, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic             unused_bits;

  // Bits outside the decoded fields (and the coordinates when the check is off).
  assign unused_bits = ^{s_awaddr, s_araddr, my_x, my_y};

  always_comb begin
    grant_r = s_arvalid && (!s_awvalid || prio_rd_q);
    grant_w = s_awvalid && (!s_arvalid || !prio_rd_q);

    aw_resp = req_resp(s_awsize, s_awburst);
    ar_resp = req_resp(s_arsize, s_arburst);
`ifdef MESH_RESP_DEST_CHECK_EN
    if (s_awaddr[COL_LSB +: 3] != my_x || s_awaddr[ROW_LSB +: 3] != my_y) aw_resp = RESP_DECERR;
    if (s_araddr[COL_LSB +: 3] != my_x || s_araddr[ROW_LSB +: 3] != my_y) ar_resp = RESP_DECERR;
`endif

    step      = fixed_q ? '0 : beat_q[IDX_W-1:0];
    idx       = base_q + step;  // wraps silently at DEPTH
    last_beat = (beat_q == {1'b0, len_q});
  end

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    base_d    = base_q;
    len_d     = len_q;
    fixed_d   = fixed_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    mem_we    = 1'b0;
    w_resp    = resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_r) begin
          state_d   = ST_RDATA;
          base_d    = s_araddr[IDX_LSB +: IDX_W];
          len_d     = s_arlen;
          fixed_d   = (s_arburst == BURST_FIXED);
          beat_d    = '0;
          resp_d    = ar_resp;
          prio_rd_d = 1'b0;
        end else if (grant_w) begin
          state_d   = ST_WDATA;
          base_d    = s_awaddr[IDX_LSB +: IDX_W];
          len_d     = s_awlen;
          fixed_d   = (s_awburst == BURST_FIXED);
          beat_d    = '0;
          resp_d    = aw_resp;
          prio_rd_d = 1'b1;
        end
      end
      ST_WDATA: begin
        if (s_wvalid) begin
          // Beats past awlen are dropped; an address-phase error stores nothing.
          if (beat_q > {1'b0, len_q}) w_resp = resp_max(w_resp, RESP_SLVERR);
          else mem_we = (resp_q == RESP_OKAY);
          if (s_wlast && !last_beat) w_resp = resp_max(w_resp, RESP_SLVERR);
          resp_d = w_resp;
          beat_d = beat_q[8] ? beat_q : beat_q + 9'd1;
          if (s_wlast) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (s_bready) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        if (s_rready) begin
          if (last_beat) state_d = ST_IDLE;
          else beat_d = beat_q + 9'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b1;
      base_q    <= '0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      beat_q    <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      base_q    <= base_d;
      len_q     <= len_d;
      fixed_q   <= fixed_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
    end
  end

  mesh_resp_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (idx),
    .wstrb (s_wstrb),
    .wdata (s_wdata),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    s_arready = (state_q == ST_IDLE) && grant_r;
    s_awready = (state_q == ST_IDLE) && grant_w;
    s_wready  = (state_q == ST_WDATA);
    s_bvalid  = (state_q == ST_WRESP);
    s_bresp   = s_bvalid ? resp_q : RESP_OKAY;
    s_rvalid  = (state_q == ST_RDATA);
    // Error reads return zero data; idle read data is forced to zero.
    s_rdata   = (s_rvalid && resp_q == RESP_OKAY) ? mem_rdata : '0;
    s_rlast   = s_rvalid && last_beat;
    s_rresp   = s_rvalid ? resp_q : RESP_OKAY;
  end

endmodule

// File: tb/tb_mesh_local_responder.sv
// Self-checking bench for mesh_local_responder: a table of bursts checked
// against a reference memory and a scoreboard, plus hand-written sequences
// for arbitration, backpressure, protocol errors and reset mid-burst.
module tb_mesh_local_responder;
  import mesh_pkg::*;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        my_x, my_y;
  logic              s_awvalid, s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic [7:0]        s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [7:0]        s_wstrb;
  logic              s_wlast;
  logic              s_bvalid, s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rlast;
  logic [1:0]        s_rresp;

  always #5 clk = ~clk;

  mesh_local_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rresp(s_rresp)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } exp_beat_t;

  typedef enum int {SEL_AWREADY, SEL_WREADY, SEL_BVALID, SEL_ARREADY, SEL_RVALID} sel_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_mem [DEPTH];
  logic [1:0]  bq[$];
  exp_beat_t   rq[$];
  vec_t        vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_val(input sel_e s);
    case (s)
      SEL_AWREADY: return s_awready;
      SEL_WREADY:  return s_wready;
      SEL_BVALID:  return s_bvalid;
      SEL_ARREADY: return s_arready;
      default:     return s_rvalid;
    endcase
  endfunction

  // Returns at a falling edge with the signal high, or after TIMEOUT cycles.
  task automatic wait_for(input sel_e s, output int waited, output bit got);
    waited = 0;
    @(negedge clk);
    got = sel_val(s);
    while (!got && waited < TIMEOUT) begin
      waited++;
      @(negedge clk);
      got = sel_val(s);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout waiting for %s", s.name());
    end
  endtask

  function automatic int idx_of(input logic [31:0] addr, input logic [1:0] burst, input int k);
    return (int'(addr >> 9) + ((burst == BURST_FIXED) ? 0 : k)) % DEPTH;
  endfunction

  task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [1:0] resp);
    exp_beat_t e;
    for (int k = 0; k <= int'(len); k++) begin
      e.data = (resp == RESP_OKAY) ? model_mem[idx_of(addr, burst, k)] : 64'h0;
      e.last = (k == int'(len));
      e.resp = resp;
      rq.push_back(e);
    end
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int w; bit got;
    s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
    wait_for(SEL_AWREADY, w, got);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [63:0] data, input logic [7:0] strb, input int nbeats);
    int w; bit got;
    for (int k = 0; k < nbeats; k++) begin
      s_wdata = data + 64'(k); s_wstrb = strb; s_wlast = (k == nbeats - 1); s_wvalid = 1'b1;
      wait_for(SEL_WREADY, w, got);
      if (k == 0) check("wready_latency", 64'(w), 64'd0);
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic b_phase();
    int w; bit got;
    s_bready = 1'b1;
    wait_for(SEL_BVALID, w, got);
    if (got) begin
      check("bvalid_latency", 64'(w), 64'd0);
      if (bq.size() > 0) check("bresp", 64'(s_bresp), 64'(bq.pop_front()));
      else check("b_unexpected", 64'(s_bvalid), 64'd0);
    end
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic r_beats(input int n);
    int w; bit got;
    exp_beat_t e;
    s_rready = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_for(SEL_RVALID, w, got);
      if (got) begin
        if (k == 0) check("rvalid_latency", 64'(w), 64'd0);
        if (rq.size() > 0) begin
          e = rq.pop_front();
          check("rdata", s_rdata, e.data);
          check("rlast", 64'(s_rlast), 64'(e.last));
          check("rresp", 64'(s_rresp), 64'(e.resp));
        end else check("r_unexpected", 64'(s_rvalid), 64'd0);
      end
      @(posedge clk); #1;
    end
    s_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [63:0] data, input logic [7:0] strb,
                          input int nbeats, input logic [1:0] exp_resp, input bit store);
    logic [63:0] d;
    int i;
    bq.push_back(exp_resp);
    if (store) begin
      for (int k = 0; k < nbeats && k <= int'(len); k++) begin
        i = idx_of(addr, burst, k);
        d = data + 64'(k);
        for (int b = 0; b < 8; b++) if (strb[b]) model_mem[i][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    aw_phase(addr, len, size, burst);
    w_beats(data, strb, nbeats);
    b_phase();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [1:0] exp_resp);
    int w; bit got;
    push_read_exp(addr, len, burst, exp_resp);
    s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
    wait_for(SEL_ARREADY, w, got);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    r_beats(int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_beat_t hold;
    rst_n = 1'b0; my_x = 3'd0; my_y = 3'd0;
    s_awvalid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_rready = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'h0;

    vecs[0]  = '{1, 32'h200,  8'd0, 3'd3, BURST_INCR,  64'h1122334455667788, 8'hFF, RESP_OKAY};
    vecs[1]  = '{0, 32'h200,  8'd0, 3'd3, BURST_INCR,  64'h0,                8'h00, RESP_OKAY};
    vecs[2]  = '{1, 32'h1E00, 8'd2, 3'd3, BURST_INCR,  64'hA5A5000000000010, 8'hFF, RESP_OKAY};
    vecs[3]  = '{0, 32'h1E00, 8'd2, 3'd3, BURST_INCR,  64'h0,                8'h00, RESP_OKAY};
    vecs[4]  = '{1, 32'h400,  8'd0, 3'd3, BURST_INCR,  64'hFFFFFFFFFFFFFFFF, 8'hFF, RESP_OKAY};
    vecs[5]  = '{1, 32'h400,  8'd0, 3'd3, BURST_INCR,  64'h0,                8'h0F, RESP_OKAY};
    vecs[6]  = '{0, 32'h400,  8'd0, 3'd3, BURST_INCR,  64'h0,                8'h00, RESP_OKAY};
    vecs[7]  = '{1, 32'h400,  8'd0, 3'd2, BURST_INCR,  64'h1234,             8'hFF, RESP_SLVERR};
    vecs[8]  = '{0, 32'h400,  8'd0, 3'd3, BURST_INCR,  64'h0,                8'h00, RESP_OKAY};
    vecs[9]  = '{1, 32'h600,  8'd1, 3'd3, BURST_FIXED, 64'hC0DE000000000000, 8'hFF, RESP_OKAY};
    vecs[10] = '{0, 32'h600,  8'd1, 3'd3, BURST_FIXED, 64'h0,                8'h00, RESP_OKAY};
    vecs[11] = '{0, 32'h200,  8'd0, 3'd3, BURST_WRAP,  64'h0,                8'h00, RESP_SLVERR};
    vecs[12] = '{0, 32'h800,  8'd3, 3'd3, BURST_INCR,  64'h0,                8'h00, RESP_OKAY};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_wready",  64'(s_wready),  64'd0);
    check("rst_bvalid",  64'(s_bvalid),  64'd0);
    check("rst_bresp",   64'(s_bresp),   64'd0);
    check("rst_rvalid",  64'(s_rvalid),  64'd0);
    check("rst_rdata",   s_rdata,        64'd0);
    check("rst_rlast",   64'(s_rlast),   64'd0);
    check("rst_rresp",   64'(s_rresp),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven bursts.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].data,
                 vecs[i].strb, int'(vecs[i].len) + 1, vecs[i].exp_resp, vecs[i].exp_resp == RESP_OKAY);
      else
        do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].exp_resp);
    end
    check("strobe_merge_model", model_mem[2], 64'hFFFFFFFF00000000);

    // Overrun: awlen 0 but two beats; only the first is stored.
    do_write(32'hC00, 8'd0, 3'd3, BURST_INCR, 64'h00000000ABCD0000, 8'hFF, 2, RESP_SLVERR, 1'b1);
    do_read(32'hC00, 8'd1, 3'd3, BURST_INCR, RESP_OKAY);
    // Early wlast: awlen 2 but wlast on the first beat.
    do_write(32'hA00, 8'd2, 3'd3, BURST_INCR, 64'h5555, 8'hFF, 1, RESP_SLVERR, 1'b1);

    // Arbitration with simultaneous AR and AW, then read backpressure.
    push_read_exp(32'h1E00, 8'd2, BURST_INCR, RESP_OKAY);
    bq.push_back(RESP_OKAY);
    model_mem[8] = 64'h0BADF00D12345678;
    s_araddr = 32'h1E00; s_arlen = 8'd2; s_arsize = 3'd3; s_arburst = BURST_INCR; s_arvalid = 1'b1;
    s_awaddr = 32'h1000; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = BURST_INCR; s_awvalid = 1'b1;
    @(negedge clk);
    check("arb_first_arready", 64'(s_arready), 64'd1);
    check("arb_first_awready", 64'(s_awready), 64'd0);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    hold = rq[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_rvalid", 64'(s_rvalid), 64'd1);
      check("bp_rdata_stable", s_rdata, hold.data);
      check("bp_no_aw_accept", 64'(s_awready), 64'd0);
      @(posedge clk); #1;
    end
    r_beats(3);
    // Both request again: write was passed over last time, so it wins now.
    push_read_exp(32'h200, 8'd0, BURST_INCR, RESP_OKAY);
    s_araddr = 32'h200; s_arlen = 8'd0; s_arsize = 3'd3; s_arburst = BURST_INCR; s_arvalid = 1'b1;
    @(negedge clk);
    check("arb_second_awready", 64'(s_awready), 64'd1);
    check("arb_second_arready", 64'(s_arready), 64'd0);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    w_beats(64'h0BADF00D12345678, 8'hFF, 1);
    b_phase();
    begin
      int w; bit got;
      wait_for(SEL_ARREADY, w, got);
      check("arb_ar_after_w", 64'(w), 64'd0);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      r_beats(1);
    end
    do_read(32'h1000, 8'd0, 3'd3, BURST_INCR, RESP_OKAY);

`ifdef MESH_RESP_DEST_CHECK_EN
    // Column 3 addressed while this core sits at column 2.
    my_x = 3'd2;
    do_read(32'h18, 8'd1, 3'd3, BURST_INCR, RESP_DECERR);
    do_write(32'h218, 8'd0, 3'd3, BURST_INCR, 64'hDEAD, 8'hFF, 1, RESP_DECERR, 1'b0);
    my_x = 3'd0;
    do_read(32'h200, 8'd0, 3'd3, BURST_INCR, RESP_OKAY);
`endif

    // Reset in the middle of a read burst.
    push_read_exp(32'h1E00, 8'd2, BURST_INCR, RESP_OKAY);
    s_araddr = 32'h1E00; s_arlen = 8'd2; s_arsize = 3'd3; s_arburst = BURST_INCR; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid", 64'(s_rvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 64'(s_rvalid), 64'd0);
    check("midrst_rdata",  s_rdata,       64'd0);
    check("midrst_rlast",  64'(s_rlast),  64'd0);
    rq.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'h0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(32'h1E00, 8'd2, 3'd3, BURST_INCR, RESP_OKAY);
    do_read(32'h400,  8'd0, 3'd3, BURST_INCR, RESP_OKAY);

    check("rq_drained", 64'(rq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
